// File: rtl/dma_stats_regs_mc.sv
// ---------------------------------------------------------------------------
// dma_stats_regs_mc
//
// Per-channel DMA statistics and control register block.
//
// Each channel exposes six registers at address {channel, index[2:0]}:
//   0 CTRL (bit0 = iface_disable, bit1 = start iface_reset pulse)
//   1 INGRESS_PKTS  2 INGRESS_BYTES  3 EGRESS_PKTS  4 EGRESS_BYTES  5 TIMEOUTS
//
// Counters live in a single-port register file (NUM_CH*5 words). Events are
// accumulated in small saturating per-counter deltas and folded into the
// register file by a background sweep, one entry per idle cycle. Register
// accesses steal the port for their cycle and the sweep pauses.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   reg_req           access request level; a rising edge starts one access
//   reg_rd_wr_L       1 = read, 0 = write
//   reg_addr          {channel, index[2:0]}, upper bits must be zero
//   reg_wr_data       write data
//   reg_rd_data       read data, valid with reg_ack
//   reg_ack           one-cycle acknowledge, one cycle after the request edge
//   iface_disable     per-channel disable (CTRL bit0)
//   iface_reset       per-channel reset pulse, RESET_EXT cycles long
//   pkt_ingress       per-channel one-cycle ingress packet strobe
//   pkt_egress        per-channel one-cycle egress packet strobe
//   pkt_len           per-channel 12-bit packet length, channel c at [12c+11:12c]
//   timeout           per-channel one-cycle timeout strobe
// ---------------------------------------------------------------------------
module dma_stats_regs_mc #(
  parameter int NUM_CH        = 4,
  parameter int ADDR_WIDTH    = 8,
  parameter int SATURATE      = 0,
  parameter int CLEAR_ON_READ = 0,
  parameter int RESET_EXT     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_req,
  input  logic                  reg_rd_wr_L,
  input  logic [ADDR_WIDTH-1:0] reg_addr,
  input  logic [31:0]           reg_wr_data,
  output logic [31:0]           reg_rd_data,
  output logic                  reg_ack,
  output logic [NUM_CH-1:0]     iface_disable,
  output logic [NUM_CH-1:0]     iface_reset,
  input  logic [NUM_CH-1:0]     pkt_ingress,
  input  logic [NUM_CH-1:0]     pkt_egress,
  input  logic [12*NUM_CH-1:0]  pkt_len,
  input  logic [NUM_CH-1:0]     timeout
);

  localparam int NUM_ENT = NUM_CH * 5;
  localparam int ENT_W   = $clog2(NUM_ENT);
  localparam logic [ENT_W-1:0] LAST_ENT = ENT_W'(NUM_ENT - 1);
  localparam logic [31:0] BAD_DATA = 32'hDEAD_BEEF;

  typedef enum logic {ST_INIT, ST_NORMAL} state_t;

  state_t            state_reg, state_next;
  logic [ENT_W-1:0]  ptr_reg, ptr_next;
  logic              req_reg;
  logic              ack_reg;
  logic [31:0]       rd_data_reg;

  logic [31:0]       mem [NUM_ENT];
  logic [15:0]       delta_q [NUM_ENT];

  // -------------------------------------------------------------------------
  // Request detection and address decode
  // -------------------------------------------------------------------------
  logic             new_req;
  logic             normal;
  logic             acc;
  logic             commit_en;
  logic [2:0]       a_ch;
  logic [2:0]       a_idx;
  logic             upper_zero;
  logic             ch_ok;
  logic             idx_ok;
  logic             addr_good;
  logic             is_ctrl;
  logic             is_cnt;
  logic [ENT_W-1:0] a_ent;
  logic             ctrl_bit;

  assign new_req   = reg_req & ~req_reg;
  assign normal    = (state_reg == ST_NORMAL);
  assign acc       = new_req & normal;
  // The sweep only owns the register-file port on cycles with no access.
  assign commit_en = normal & ~new_req;

  assign a_ch  = reg_addr[5:3];
  assign a_idx = reg_addr[2:0];

  always_comb begin
    upper_zero = 1'b1;
    for (int i = 6; i < ADDR_WIDTH; i++) begin
      if (reg_addr[i]) upper_zero = 1'b0;
    end
  end

  assign ch_ok     = ({1'b0, a_ch} < 4'(NUM_CH));
  assign idx_ok    = (a_idx < 3'd6);
  assign addr_good = upper_zero & ch_ok & idx_ok;
  assign is_ctrl   = (a_idx == 3'd0);
  assign is_cnt    = addr_good & ~is_ctrl;
  // Counter entry number: channel*5 + (index-1); only meaningful when is_cnt.
  assign a_ent     = ENT_W'(a_ch) * ENT_W'(5) + ENT_W'(a_idx) - ENT_W'(1);

  always_comb begin
    ctrl_bit = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (a_ch == 3'(c)) ctrl_bit = iface_disable[c];
    end
  end

  // -------------------------------------------------------------------------
  // INIT / NORMAL state machine and sweep pointer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_INIT;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      ST_INIT: begin
        // Zeroing runs every cycle regardless of register traffic.
        if (ptr_reg == LAST_ENT) begin
          ptr_next   = '0;
          state_next = ST_NORMAL;
        end else begin
          ptr_next = ptr_reg + 1'b1;
        end
      end
      ST_NORMAL: begin
        if (!new_req) begin
          ptr_next = (ptr_reg == LAST_ENT) ? '0 : ptr_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_INIT;
        ptr_next   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Sweep commit value
  // -------------------------------------------------------------------------
  logic [32:0] sum33;
  logic [31:0] commit_val;

  assign sum33      = {1'b0, mem[ptr_reg]} + {17'b0, delta_q[ptr_reg]};
  assign commit_val = ((SATURATE != 0) && sum33[32]) ? 32'hFFFF_FFFF : sum33[31:0];

  // -------------------------------------------------------------------------
  // Register file: one write per cycle, owned by INIT, an access, or the sweep
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!normal) begin
      mem[ptr_reg] <= '0;
    end else if (new_req) begin
      if (is_cnt) begin
        if (!reg_rd_wr_L) begin
          mem[a_ent] <= reg_wr_data;
        end else if (CLEAR_ON_READ != 0) begin
          mem[a_ent] <= '0;
        end
      end
    end else begin
      mem[ptr_reg] <= commit_val;
    end
  end

  // -------------------------------------------------------------------------
  // Request edge register, acknowledge and read data
  // -------------------------------------------------------------------------
  // req_reg simply tracks the request level so a request held across reset
  // is not seen as a fresh edge afterwards.
  always_ff @(posedge clk) begin
    req_reg <= reg_req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_reg     <= 1'b0;
      rd_data_reg <= '0;
    end else begin
      ack_reg <= new_req;
      if (new_req && reg_rd_wr_L) begin
        if (!normal || !addr_good) begin
          rd_data_reg <= BAD_DATA;
        end else if (is_ctrl) begin
          rd_data_reg <= {31'b0, ctrl_bit};
        end else begin
          rd_data_reg <= mem[a_ent];
        end
      end
    end
  end

  assign reg_ack     = ack_reg;
  assign reg_rd_data = rd_data_reg;

  // -------------------------------------------------------------------------
  // Per-channel CTRL flops and iface_reset pulse counters
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ctrl
      logic       dis_reg;
      logic [6:0] cnt_reg;
      logic       wr_hit;

      assign wr_hit = acc & ~reg_rd_wr_L & addr_good & is_ctrl & (a_ch == 3'(gi));

      always_ff @(posedge clk) begin
        if (reset) begin
          dis_reg <= 1'b0;
          cnt_reg <= '0;
        end else begin
          if (wr_hit) begin
            dis_reg <= reg_wr_data[0];
          end
          // Bit1 is a trigger only; a rewrite mid-pulse reloads the count.
          if (wr_hit && reg_wr_data[1]) begin
            cnt_reg <= 7'(RESET_EXT);
          end else if (cnt_reg != 7'd0) begin
            cnt_reg <= cnt_reg - 7'd1;
          end
        end
      end

      assign iface_disable[gi] = dis_reg;
      assign iface_reset[gi]   = (cnt_reg != 7'd0);
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Per-counter saturating deltas
  // -------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NUM_ENT; gi++) begin : g_delta
      localparam int CH   = gi / 5;
      localparam int K    = gi % 5;
      localparam int MAXV = (K == 1 || K == 3) ? 65535 : 255;

      logic        ev;
      logic [15:0] inc;
      logic [15:0] d_reg;
      logic [16:0] sum17;
      logic        commit_hit;

      if (K < 2) begin : g_ing
        assign ev = pkt_ingress[CH];
      end else if (K < 4) begin : g_egr
        assign ev = pkt_egress[CH];
      end else begin : g_tmo
        assign ev = timeout[CH];
      end

      if (K == 1 || K == 3) begin : g_bytes
        assign inc = ev ? {4'b0, pkt_len[12*CH +: 12]} : 16'd0;
      end else begin : g_count
        assign inc = {15'b0, ev};
      end

      assign sum17      = {1'b0, d_reg} + {1'b0, inc};
      assign commit_hit = commit_en && (ptr_reg == ENT_W'(gi));

      always_ff @(posedge clk) begin
        if (reset) begin
          d_reg <= '0;
        end else if (commit_hit) begin
          // The old delta is being folded in this cycle; keep only the new event.
          d_reg <= inc;
        end else if (sum17 > 17'(MAXV)) begin
          d_reg <= 16'(MAXV);
        end else begin
          d_reg <= sum17[15:0];
        end
      end

      assign delta_q[gi] = d_reg;
    end
  endgenerate

endmodule

// File: tb/tb_dma_stats_regs_mc.sv
module tb_dma_stats_regs_mc;
  localparam int NUM_CH  = 4;
  localparam int NUM_ENT = NUM_CH * 5;
  localparam int RE0     = 32;
  localparam int RE1     = 5;
  localparam int SWEEP_WAIT = 2 * NUM_ENT + 4;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset = 1'b1;
  logic                 reg_req = 1'b0;
  logic                 reg_rd_wr_L = 1'b1;
  logic [7:0]           reg_addr = '0;
  logic [31:0]          reg_wr_data = '0;
  logic [NUM_CH-1:0]    pkt_ingress = '0;
  logic [NUM_CH-1:0]    pkt_egress = '0;
  logic [12*NUM_CH-1:0] pkt_len = '0;
  logic [NUM_CH-1:0]    timeout = '0;

  logic [31:0]       rd0, rd1;
  logic              ack0, ack1;
  logic [NUM_CH-1:0] dis0, dis1, ifr0, ifr1;

  // dut0: wrapping counters, plain reads; dut1: saturating, clear-on-read.
  dma_stats_regs_mc #(.NUM_CH(NUM_CH), .ADDR_WIDTH(8), .SATURATE(0),
                      .CLEAR_ON_READ(0), .RESET_EXT(RE0)) dut0 (
    .clk(clk), .reset(reset), .reg_req(reg_req), .reg_rd_wr_L(reg_rd_wr_L),
    .reg_addr(reg_addr), .reg_wr_data(reg_wr_data), .reg_rd_data(rd0),
    .reg_ack(ack0), .iface_disable(dis0), .iface_reset(ifr0),
    .pkt_ingress(pkt_ingress), .pkt_egress(pkt_egress), .pkt_len(pkt_len),
    .timeout(timeout));

  dma_stats_regs_mc #(.NUM_CH(NUM_CH), .ADDR_WIDTH(8), .SATURATE(1),
                      .CLEAR_ON_READ(1), .RESET_EXT(RE1)) dut1 (
    .clk(clk), .reset(reset), .reg_req(reg_req), .reg_rd_wr_L(reg_rd_wr_L),
    .reg_addr(reg_addr), .reg_wr_data(reg_wr_data), .reg_rd_data(rd1),
    .reg_ack(ack1), .iface_disable(dis1), .iface_reset(ifr1),
    .pkt_ingress(pkt_ingress), .pkt_egress(pkt_egress), .pkt_len(pkt_len),
    .timeout(timeout));

  int tests = 0;
  int fails = 0;

  // Reference model: architectural counter totals per entry.
  logic [31:0] exp0 [NUM_ENT];
  logic [31:0] exp1 [NUM_ENT];

  logic [31:0]       got0, got1;
  logic [NUM_CH-1:0] ifr0_at_ack, ifr1_at_ack;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  task automatic model_clear();
    for (int e = 0; e < NUM_ENT; e++) begin
      exp0[e] = '0;
      exp1[e] = '0;
    end
  endtask

  task automatic model_event(input int e, input logic [31:0] v);
    exp0[e] = exp0[e] + v;
    exp1[e] = sat_add(exp1[e], v);
  endtask

  // One register access; returns at one cycle after the acknowledge.
  task automatic access(input logic rd, input logic [7:0] a, input logic [31:0] wd);
    reg_rd_wr_L = rd;
    reg_addr    = a;
    reg_wr_data = wd;
    reg_req     = 1'b1;
    chk($sformatf("ack0_pre_a%02h", a), {31'b0, ack0}, 32'd0);
    chk($sformatf("ack1_pre_a%02h", a), {31'b0, ack1}, 32'd0);
    tick(1);
    chk($sformatf("ack0_a%02h", a), {31'b0, ack0}, 32'd1);
    chk($sformatf("ack1_a%02h", a), {31'b0, ack1}, 32'd1);
    got0 = rd0;
    got1 = rd1;
    ifr0_at_ack = ifr0;
    ifr1_at_ack = ifr1;
    reg_req = 1'b0;
    tick(1);
    chk($sformatf("ack0_post_a%02h", a), {31'b0, ack0}, 32'd0);
    chk($sformatf("ack1_post_a%02h", a), {31'b0, ack1}, 32'd0);
    $display("[TB] %s addr=0x%02h wd=0x%08h rd0=0x%08h rd1=0x%08h",
             rd ? "RD" : "WR", a, wd, got0, got1);
  endtask

  function automatic logic [7:0] ent_addr(input int e);
    return 8'((e / 5) * 8 + (e % 5) + 1);
  endfunction

  task automatic read_entry(input int e);
    access(1'b1, ent_addr(e), 32'd0);
    chk($sformatf("cnt_e%0d_dut0", e), got0, exp0[e]);
    chk($sformatf("cnt_e%0d_dut1", e), got1, exp1[e]);
    exp1[e] = '0;
  endtask

  task automatic write_entry(input int e, input logic [31:0] v);
    access(1'b0, ent_addr(e), v);
    exp0[e] = v;
    exp1[e] = v;
  endtask

  task automatic read_bad(input logic [7:0] a);
    access(1'b1, a, 32'd0);
    chk($sformatf("bad0_a%02h", a), got0, BAD);
    chk($sformatf("bad1_a%02h", a), got1, BAD);
  endtask

  task automatic ev_cycle(input logic [NUM_CH-1:0] ig, input logic [NUM_CH-1:0] eg,
                          input logic [NUM_CH-1:0] tm, input logic [12*NUM_CH-1:0] ln);
    pkt_ingress = ig;
    pkt_egress  = eg;
    timeout     = tm;
    pkt_len     = ln;
    for (int c = 0; c < NUM_CH; c++) begin
      logic [31:0] l;
      l = {20'b0, ln[12*c +: 12]};
      if (ig[c]) begin model_event(c*5 + 0, 32'd1); model_event(c*5 + 1, l); end
      if (eg[c]) begin model_event(c*5 + 2, 32'd1); model_event(c*5 + 3, l); end
      if (tm[c]) model_event(c*5 + 4, 32'd1);
    end
    tick(1);
    pkt_ingress = '0;
    pkt_egress  = '0;
    timeout     = '0;
    pkt_len     = '0;
  endtask

  task automatic measure_pulse(input string tag);
    int c0, c1;
    c0 = int'(ifr0_at_ack[2]);
    c1 = int'(ifr1_at_ack[2]);
    for (int i = 0; i < 70; i++) begin
      c0 += int'(ifr0[2]);
      c1 += int'(ifr1[2]);
      tick(1);
    end
    chk({tag, "_len0"}, 32'(c0), 32'(RE0));
    chk({tag, "_len1"}, 32'(c1), 32'(RE1));
  endtask

  initial begin
    logic [31:0] r;
    logic [12*NUM_CH-1:0] ln;

    model_clear();
    tick(3);
    reset = 1'b0;

    // Reset values
    chk("rst_ack0", {31'b0, ack0}, 32'd0);
    chk("rst_ack1", {31'b0, ack1}, 32'd0);
    chk("rst_rd0", rd0, 32'd0);
    chk("rst_rd1", rd1, 32'd0);
    chk("rst_dis0", {28'b0, dis0}, 32'd0);
    chk("rst_dis1", {28'b0, dis1}, 32'd0);
    chk("rst_ifr0", {28'b0, ifr0}, 32'd0);
    chk("rst_ifr1", {28'b0, ifr1}, 32'd0);

    // Read during INIT (request edge on first cycle after reset)
    read_bad(8'h09);

    // Reset in the middle of INIT restarts the zeroing from entry 0
    tick(8);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    model_clear();
    tick(14);
    access(1'b0, 8'h01, 32'h0000_1234);  // edge 15: still INIT, ignored
    access(1'b0, 8'h10, 32'h0000_0003);  // edge 17: CTRL write in INIT, ignored
    tick(1);
    read_bad(8'h01);                     // edge 20: last INIT cycle
    read_entry(0);                       // edge 22: NORMAL, entry still zero
    chk("init_wr_dis0", {28'b0, dis0}, 32'd0);
    chk("init_wr_dis1", {28'b0, dis1}, 32'd0);
    chk("init_wr_ifr0", {28'b0, ifr0}, 32'd0);
    chk("init_wr_ifr1", {28'b0, ifr1}, 32'd0);

    // Reset arriving with a request edge suppresses the acknowledge
    reg_rd_wr_L = 1'b1;
    reg_addr    = 8'h01;
    reg_req     = 1'b1;
    reset       = 1'b1;
    tick(1);
    chk("rst_mid_ack0", {31'b0, ack0}, 32'd0);
    chk("rst_mid_ack1", {31'b0, ack1}, 32'd0);
    reg_req = 1'b0;
    tick(1);
    chk("rst_mid_ack0b", {31'b0, ack0}, 32'd0);
    chk("rst_mid_ack1b", {31'b0, ack1}, 32'd0);
    reset = 1'b0;
    model_clear();

    // Read ch3 EGRESS_BYTES after INIT completes
    tick(NUM_ENT + 1);
    read_entry(18);

    // Three ingress packets on ch1
    ln = '0; ln[12*1 +: 12] = 12'd64;
    ev_cycle(4'b0010, 4'b0000, 4'b0000, ln);
    tick(1);
    ln = '0; ln[12*1 +: 12] = 12'd100;
    ev_cycle(4'b0010, 4'b0000, 4'b0000, ln);
    ln = '0; ln[12*1 +: 12] = 12'd1500;
    ev_cycle(4'b0010, 4'b0000, 4'b0000, ln);
    tick(SWEEP_WAIT);
    read_entry(5);
    chk("ch1_ing_pkts0", got0, 32'd3);
    chk("ch1_ing_pkts1", got1, 32'd3);
    read_entry(6);
    chk("ch1_ing_bytes0", got0, 32'd1664);
    chk("ch1_ing_bytes1", got1, 32'd1664);

    // Counter wrap versus saturation on ch0 TIMEOUTS
    write_entry(4, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      ev_cycle(4'b0000, 4'b0000, 4'b0001, '0);
      tick(1);
    end
    tick(SWEEP_WAIT);
    read_entry(4);
    chk("tmo_wrap0", got0, 32'h0000_0001);
    chk("tmo_sat1", got1, 32'hFFFF_FFFF);

    // Clear-on-read on ch2 EGRESS_PKTS
    for (int i = 0; i < 5; i++) begin
      r = $urandom;
      ln = '0; ln[12*2 +: 12] = 12'(r % 1501);
      ev_cycle(4'b0000, 4'b0100, 4'b0000, ln);
    end
    tick(SWEEP_WAIT);
    read_entry(12);
    chk("egr_pkts0", got0, 32'd5);
    chk("egr_pkts1", got1, 32'd5);
    read_entry(12);
    chk("egr_reread0", got0, 32'd5);
    chk("egr_reread1", got1, 32'd0);
    read_entry(13);

    // CTRL on ch2: disable + reset pulse
    chk("ctrl_ifr_pre0", {28'b0, ifr0}, 32'd0);
    access(1'b0, 8'h10, 32'h0000_0003);
    chk("ctrl_ifr_ack0", {31'b0, ifr0_at_ack[2]}, 32'd1);
    chk("ctrl_ifr_ack1", {31'b0, ifr1_at_ack[2]}, 32'd1);
    measure_pulse("pulse");
    chk("ctrl_dis0", {28'b0, dis0}, 32'h4);
    chk("ctrl_dis1", {28'b0, dis1}, 32'h4);
    chk("ctrl_ifr_done0", {28'b0, ifr0}, 32'd0);
    chk("ctrl_ifr_done1", {28'b0, ifr1}, 32'd0);
    access(1'b1, 8'h10, 32'd0);
    chk("ctrl_rd0", got0, 32'h1);
    chk("ctrl_rd1", got1, 32'h1);

    // Rewrite during a pulse reloads the full length
    access(1'b0, 8'h10, 32'h0000_0002);
    tick(8);
    access(1'b0, 8'h10, 32'h0000_0002);
    measure_pulse("restart");
    chk("ctrl_dis_clr0", {28'b0, dis0}, 32'd0);
    chk("ctrl_dis_clr1", {28'b0, dis1}, 32'd0);

    // Bad addresses
    read_bad(8'h06);
    read_bad(8'h07);
    read_bad(8'h20);
    read_bad(8'h27);
    read_bad(8'h40);
    read_bad(8'h41);
    access(1'b0, 8'h06, 32'hFFFF_FFFF);
    access(1'b0, 8'h0E, 32'h0000_0003);
    access(1'b0, 8'h20, 32'h0000_0003);
    access(1'b0, 8'h28, 32'h0000_0003);
    access(1'b0, 8'h40, 32'h0000_0003);
    access(1'b0, 8'h42, 32'h1234_5678);
    tick(2);
    chk("bad_wr_dis0", {28'b0, dis0}, 32'd0);
    chk("bad_wr_dis1", {28'b0, dis1}, 32'd0);
    chk("bad_wr_ifr0", {28'b0, ifr0}, 32'd0);
    chk("bad_wr_ifr1", {28'b0, ifr1}, 32'd0);
    for (int e = 0; e < NUM_ENT; e++) read_entry(e);

    // Randomized traffic rounds
    for (int rnd = 0; rnd < 4; rnd++) begin
      for (int cyc = 0; cyc < 24; cyc++) begin
        logic [NUM_CH-1:0] ig, eg, tm;
        r  = $urandom; ig = r[3:0];
        r  = $urandom; eg = r[3:0];
        r  = $urandom; tm = r[3:0] & r[7:4];
        for (int c = 0; c < NUM_CH; c++) begin
          r = $urandom_range(0, 1500);
          ln[12*c +: 12] = r[11:0];
        end
        ev_cycle(ig, eg, tm, ln);
      end
      tick(SWEEP_WAIT);
      for (int e = 0; e < NUM_ENT; e++) read_entry(e);
      for (int w = 0; w < 4; w++) begin
        int e;
        logic [31:0] v;
        e = int'($urandom_range(0, NUM_ENT - 1));
        v = $urandom;
        if (v[0]) v = v | 32'hFFFF_0000;
        write_entry(e, v);
      end
    end
    // Final settle and full readback after the last writes
    for (int cyc = 0; cyc < 16; cyc++) begin
      logic [NUM_CH-1:0] ig, eg;
      r  = $urandom; ig = r[3:0];
      r  = $urandom; eg = r[3:0];
      for (int c = 0; c < NUM_CH; c++) begin
        r = $urandom_range(0, 1500);
        ln[12*c +: 12] = r[11:0];
      end
      ev_cycle(ig, eg, 4'b1111, ln);
    end
    tick(SWEEP_WAIT);
    for (int e = 0; e < NUM_ENT; e++) read_entry(e);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
